// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t  : execute-stage operand source select
//   hz_state_t : memory-handshake sequencer states
//   PC_REG     : architectural PC register index, never forwarded
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RD  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ABORT    = 2'b10
  } hz_state_t;

  localparam int unsigned PC_REG = 15;

endpackage : hazard_pkg

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard-controller signal bundle.
//   master : pipeline side (drives register addresses, enables, memory status;
//            receives forwarding selects, stall/flush controls, error, counter)
//   slave  : hazard controller side
// Parameters: REG_AW register-address width, CNT_W stall-counter width.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
);
  import hazard_pkg::*;

  logic [REG_AW-1:0] RA1D, RA2D;
  logic [REG_AW-1:0] RA1E, RA2E;
  logic [REG_AW-1:0] WA3E, WA3M, WA3W;
  logic              RegWriteM, RegWriteW;
  logic              MemtoRegE;
  logic              BranchTakenE;
  logic              MemReqM, MemReadyM;

  fwd_sel_t          ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW;
  logic              MemErr;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemErr, StallCount
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemErr, StallCount
  );

endinterface : hazard_ctrl_if

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding comparator for the execute stage.
//   ra_e_i        : E-stage source register address
//   wa_m_i/wa_w_i : M/W-stage destination addresses
//   reg_write_*_i : M/W-stage write enables
//   fwd_o         : operand source select (M wins over W; PC never forwarded)
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 4
) (
  input  logic [REG_AW-1:0] ra_e_i,
  input  logic [REG_AW-1:0] wa_m_i,
  input  logic [REG_AW-1:0] wa_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  output fwd_sel_t          fwd_o
);

  logic not_pc;
  assign not_pc = (ra_e_i != REG_AW'(PC_REG));

  // Priority select: the younger M-stage result shadows the W-stage one.
  always_comb begin
    fwd_o = FWD_RD;
    if (reg_write_m_i && (wa_m_i == ra_e_i) && not_pc) begin
      fwd_o = FWD_MEM;
    end else if (reg_write_w_i && (wa_w_i == ra_e_i) && not_pc) begin
      fwd_o = FWD_WB;
    end
  end

endmodule : fwd_sel

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage F/D/E/M/W core.
//   clk, rst : core clock, synchronous active-high reset
//   hz       : hazard_ctrl_if.slave bundle (addresses, enables, memory status in;
//              ForwardAE/BE, Stall*, Flush*, MemErr, StallCount out)
// Forwarding selects and stall/flush controls are combinational (same-cycle);
// MemErr and StallCount are registered.
// Optional: define HAZARD_PERF_CNT_EN to build the saturating stall counter;
// otherwise StallCount is tied to zero.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t         state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_err_q, mem_err_d;

  fwd_sel_t fwd_a, fwd_b;
  logic     stall_f, stall_d, stall_e, stall_m;
  logic     flush_d, flush_e, flush_w;
  logic     mem_busy, ldstall;

  // Operand forwarding comparators
  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .ra_e_i        (hz.RA1E),
    .wa_m_i        (hz.WA3M),
    .wa_w_i        (hz.WA3W),
    .reg_write_m_i (hz.RegWriteM),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .ra_e_i        (hz.RA2E),
    .wa_m_i        (hz.WA3M),
    .wa_w_i        (hz.WA3W),
    .reg_write_m_i (hz.RegWriteM),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (fwd_b)
  );

  assign mem_busy = hz.MemReqM && !hz.MemReadyM;
  assign ldstall  = hz.MemtoRegE &&
                    ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));

  // Sequencer next state and same-cycle stall/flush decode
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          // Freeze F..M and bubble W starting this very cycle.
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          flush_w = 1'b1;
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end else if (hz.BranchTakenE) begin
          // Taken branch squashes the wrong-path D/E and overrides ldstall.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (ldstall) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end

      MEM_WAIT: begin
        // Branch/ldstall are ignored here; the held D/E state is
        // re-evaluated in RUN once memory releases.
        if (hz.MemReadyM) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          flush_w = 1'b1;
          if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
            mem_err_d = 1'b1;
            state_d   = ABORT;
            wcnt_d    = '0;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end

      ABORT: begin
        // Retire the timed-out M instruction as a bubble and squash D/E.
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_w = 1'b1;
        state_d = RUN;
      end

      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase

    // All controls are quiet during the reset cycle.
    if (rst) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
    end
  end

  // Sequencer state, wait counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles with the fetch stage held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.StallCount = stall_cnt_q;
`else
  assign hz.StallCount = '0;
`endif

  assign hz.ForwardAE = rst ? FWD_RD : fwd_a;
  assign hz.ForwardBE = rst ? FWD_RD : fwd_b;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.MemErr    = mem_err_q;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int unsigned REG_AW  = 4;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

  hazard_ctrl #(
    .REG_AW      (REG_AW),
    .MEM_TIMEOUT (TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int checks = 0;
  int errors = 0;

  // Model state: cycles the current access has been stalled (0 = no access
  // outstanding), pending abort bubble, sticky error, stalled-cycle tally.
  int busy_m  = 0;
  bit abort_m = 0;
  bit err_m   = 0;
  int cnt_m   = 0;

  int n_busy;
  bit n_abort, n_err;
  int e_fa, e_fb;
  bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int fwd_exp(input int ra);
    if (ra == 15) return 0;
    if (hz.RegWriteM && int'(hz.WA3M) == ra) return 2;
    if (hz.RegWriteW && int'(hz.WA3W) == ra) return 1;
    return 0;
  endfunction

  // Expected outputs for the current inputs plus the model's next state.
  task automatic model_eval();
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw} = '0;
    e_fa = 0; e_fb = 0;
    n_busy = busy_m; n_abort = 0; n_err = err_m;
    if (rst) begin
      n_busy = 0;
      n_err  = 0;
    end else begin
      e_fa = fwd_exp(int'(hz.RA1E));
      e_fb = fwd_exp(int'(hz.RA2E));
      if (abort_m) begin
        e_fd = 1; e_fe = 1; e_fw = 1;
      end else if (busy_m > 0) begin
        if (hz.MemReadyM) begin
          n_busy = 0;
        end else begin
          {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111;
          if (busy_m == int'(TIMEOUT)) begin
            n_err = 1; n_abort = 1; n_busy = 0;
          end else begin
            n_busy = busy_m + 1;
          end
        end
      end else if (hz.MemReqM && !hz.MemReadyM) begin
        {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111;
        n_busy = 1;
      end else if (hz.BranchTakenE) begin
        e_fd = 1; e_fe = 1;
      end else if (hz.MemtoRegE && (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D)) begin
        e_sf = 1; e_sd = 1; e_fe = 1;
      end
    end
  endtask

  task automatic check_outputs();
    int exp_cnt;
`ifdef HAZARD_PERF_CNT_EN
    exp_cnt = cnt_m;
`else
    exp_cnt = 0;
`endif
    model_eval();
    chk("ForwardAE",  int'(hz.ForwardAE), e_fa);
    chk("ForwardBE",  int'(hz.ForwardBE), e_fb);
    chk("StallF",     hz.StallF, e_sf);
    chk("StallD",     hz.StallD, e_sd);
    chk("StallE",     hz.StallE, e_se);
    chk("StallM",     hz.StallM, e_sm);
    chk("FlushD",     hz.FlushD, e_fd);
    chk("FlushE",     hz.FlushE, e_fe);
    chk("FlushW",     hz.FlushW, e_fw);
    chk("MemErr",     hz.MemErr, err_m);
    chk("StallCount", int'(hz.StallCount), exp_cnt);
  endtask

  task automatic model_step();
    if (rst) cnt_m = 0;
    else if (e_sf && cnt_m < int'(CNT_MAX)) cnt_m++;
    busy_m  = n_busy;
    abort_m = n_abort;
    err_m   = n_err;
  endtask

  // One clock: check at the falling edge, advance the model, then return
  // just after the rising edge so the caller can drive the next inputs.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    hz.RA1D = '0; hz.RA2D = '0; hz.RA1E = '0; hz.RA2E = '0;
    hz.WA3E = 4'd9; hz.WA3M = 4'd10; hz.WA3W = 4'd11;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.MemtoRegE = 0;
    hz.BranchTakenE = 0; hz.MemReqM = 0; hz.MemReadyM = 0;
  endtask

  function automatic logic [REG_AW-1:0] rnd_reg();
    int unsigned r;
    r = $urandom_range(0, 5);
    return (r == 5) ? REG_AW'(15) : REG_AW'(r);
  endfunction

  initial begin
    set_idle();
    rst = 1;
    @(posedge clk); #1;
    cycle();
    rst = 0;
    cycle();

    // Forwarding priority and PC exclusion
    hz.WA3M = 4'd3; hz.RegWriteM = 1; hz.WA3W = 4'd3; hz.RegWriteW = 1; hz.RA1E = 4'd3;
    #1 chk("fwd_mem", int'(hz.ForwardAE), 2);
    cycle();
    hz.RegWriteM = 0;
    #1 chk("fwd_wb", int'(hz.ForwardAE), 1);
    cycle();
    hz.RegWriteM = 1; hz.WA3M = 4'd15; hz.WA3W = 4'd15; hz.RA1E = 4'd15;
    #1 chk("fwd_pc", int'(hz.ForwardAE), 0);
    cycle();
    set_idle();

    // Load-use stall, then branch overriding it
    hz.MemtoRegE = 1; hz.WA3E = 4'd5; hz.RA2D = 4'd5;
    #1 chk("ldstall_f", hz.StallF, 1);
    cycle();
    hz.MemtoRegE = 0;
    #1 chk("ldstall_once", hz.StallF, 0);
    cycle();
    hz.MemtoRegE = 1; hz.BranchTakenE = 1;
    #1 chk("br_ovr_stall", hz.StallF, 0);
    chk("br_ovr_flushd", hz.FlushD, 1);
    cycle();
    set_idle();

    // Memory wait of three stalled cycles, then ready
    hz.MemReqM = 1;
    for (int i = 0; i < 4; i++) begin
      hz.MemReadyM = (i == 3);
      #1 chk("memwait_stallm", hz.StallM, (i < 3) ? 1 : 0);
      chk("memwait_flushw", hz.FlushW, (i < 3) ? 1 : 0);
      cycle();
    end
    set_idle();
    #1 chk("memwait_noerr", hz.MemErr, 0);
    cycle();

    // Timeout: entry + TIMEOUT wait cycles, one abort cycle, sticky error
    hz.MemReqM = 1;
    for (int i = 0; i < int'(TIMEOUT) + 1; i++) begin
      #1 chk("tmo_stall", hz.StallF, 1);
      cycle();
    end
    #1 chk("abort_flushd", hz.FlushD, 1);
    chk("abort_flushe", hz.FlushE, 1);
    chk("abort_flushw", hz.FlushW, 1);
    chk("abort_nostall", hz.StallM, 0);
    chk("abort_err", hz.MemErr, 1);
    cycle();
    hz.MemReqM = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("err_sticky", hz.MemErr, 1);
      cycle();
    end

    // Branch held during a memory wait flushes only after release
    hz.MemReqM = 1; hz.BranchTakenE = 1;
    cycle();
    #1 chk("br_in_wait", hz.FlushD, 0);
    cycle();
    hz.MemReadyM = 1;
    #1 chk("br_release", hz.FlushD, 0);
    cycle();
    hz.MemReqM = 0; hz.MemReadyM = 0;
    #1 chk("br_after_wait", hz.FlushD, 1);
    cycle();
    set_idle();

    // Stall-counter saturation from a clean reset
    rst = 1;
    cycle();
    rst = 0;
    hz.MemtoRegE = 1; hz.WA3E = 4'd2; hz.RA1D = 4'd2;
    for (int i = 0; i < 20; i++) cycle();
    set_idle();
`ifdef HAZARD_PERF_CNT_EN
    #1 chk("cnt_sat", int'(hz.StallCount), CNT_MAX);
`else
    #1 chk("cnt_tied", int'(hz.StallCount), 0);
`endif
    cycle();

    // Reset in the middle of a memory wait
    hz.MemReqM = 1;
    cycle();
    cycle();
    rst = 1;
    #1 chk("rst_stall", hz.StallF, 0);
    cycle();
    rst = 0; hz.MemReqM = 0;
    #1 chk("rst_run_stall", hz.StallM, 0);
    chk("rst_cnt", int'(hz.StallCount), 0);
    chk("rst_err", hz.MemErr, 0);
    cycle();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      hz.RA1D = rnd_reg(); hz.RA2D = rnd_reg();
      hz.RA1E = rnd_reg(); hz.RA2E = rnd_reg();
      hz.WA3E = rnd_reg(); hz.WA3M = rnd_reg(); hz.WA3W = rnd_reg();
      hz.RegWriteM    = 1'($urandom_range(0, 1));
      hz.RegWriteW    = 1'($urandom_range(0, 1));
      hz.MemtoRegE    = ($urandom_range(0, 2) == 0);
      hz.BranchTakenE = ($urandom_range(0, 4) == 0);
      hz.MemReqM      = ($urandom_range(0, 2) == 0);
      hz.MemReadyM    = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hazard_ctrl
